cipu_feeder: RTL and testbench

CIPU_FEEDER -- requirements
Module: cipu_feeder

---
 rtl/cipu_feeder.sv | 177 +++++++++++++++++
 tb/tb_cipu_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cipu_feeder.sv
// CIPU feeder: buffers people and thing characters, then streams
// both channels concurrently to the CIPU with '$' terminators.
module cipu_feeder (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic [3:0] wr_num,
  input  logic       start,
  input  logic       done_fifo,
  input  logic       done_thing,
  input  logic       done_fifo2,
  output logic       ready_fifo,
  output logic       ready_lifo,
  output logic [7:0] people_thing_in,
  output logic [7:0] thing_in,
  output logic [3:0] thing_num,
  output logic       busy,
  output logic       finish,
  output logic       wr_full
);

  typedef enum logic [1:0] {
    P_IDLE, P_READY, P_SEND, P_WAIT
  } p_st_t;

  typedef enum logic [2:0] {
    T_IDLE, T_READY, T_SEND, T_WAITG, T_WAIT
  } t_st_t;

  logic [7:0]  r_pmem [32];
  logic [11:0] r_tmem [32];
  logic [5:0]  r_pcnt, r_tcnt;
  logic [5:0]  r_pidx, r_tidx;
  logic        r_busy, r_fin;
  logic        r_pdone, r_tdone;
  p_st_t       r_pst;
  t_st_t       r_tst;
  logic        r_rdyf, r_rdyl;
  logic [7:0]  r_pout, r_tout;
  logic [3:0]  r_tnum;

  logic        w_pfull, w_tfull;
  logic        w_pwr, w_twr;
  logic        w_go, w_fin;
  logic [11:0] w_tent;
  logic        w_temit;

  assign w_pfull = (r_pcnt == 6'd32);
  assign w_tfull = (r_tcnt == 6'd32);
  assign wr_full = wr_sel ? w_tfull : w_pfull;
  assign w_pwr   = wr_en & ~r_busy & ~wr_sel & ~w_pfull;
  assign w_twr   = wr_en & ~r_busy & wr_sel & ~w_tfull;
  assign w_go    = start & ~r_busy;
  assign w_fin   = r_pdone & r_tdone;
  assign w_tent  = r_tmem[r_tidx[4:0]];
  assign w_temit = (r_tst == T_READY) | (r_tst == T_SEND)
                 | ((r_tst == T_WAITG) & done_thing);

  assign ready_fifo      = r_rdyf;
  assign ready_lifo      = r_rdyl;
  assign people_thing_in = r_pout;
  assign thing_in        = r_tout;
  assign thing_num       = r_tnum;
  assign busy            = r_busy;
  assign finish          = r_fin;

  // Buffer storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_pwr) r_pmem[r_pcnt[4:0]] <= wr_data;
    if (w_twr) r_tmem[r_tcnt[4:0]] <= {wr_num, wr_data};
  end

  // Fill counts, busy window and the finish pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_tcnt <= '0;
      r_busy <= 1'b0;
      r_fin  <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      if (w_fin) begin
        r_fin  <= 1'b1;
        r_busy <= 1'b0;
        r_pcnt <= '0;
        r_tcnt <= '0;
      end else begin
        if (w_go)  r_busy <= 1'b1;
        if (w_pwr) r_pcnt <= r_pcnt + 6'd1;
        if (w_twr) r_tcnt <= r_tcnt + 6'd1;
      end
    end
  end

  // People channel: ready pulse, entries in order, '$', wait done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pst   <= P_IDLE;
      r_rdyf  <= 1'b0;
      r_pout  <= 8'h00;
      r_pidx  <= '0;
      r_pdone <= 1'b0;
    end else begin
      r_rdyf <= 1'b0;
      unique case (r_pst)
        P_IDLE: begin
          r_pout <= 8'h00;
          if (w_go) begin
            r_pst  <= P_READY;
            r_rdyf <= 1'b1;
            r_pidx <= '0;
          end
        end
        P_READY, P_SEND: begin
          if (r_pidx < r_pcnt) begin
            r_pout <= r_pmem[r_pidx[4:0]];
            r_pidx <= r_pidx + 6'd1;
            r_pst  <= P_SEND;
          end else begin
            r_pout <= 8'h24;
            r_pst  <= P_WAIT;
          end
        end
        P_WAIT: begin
          r_pout <= 8'h00;
          if (done_fifo) begin
            r_pdone <= 1'b1;
            r_pst   <= P_IDLE;
          end
        end
      endcase
      if (w_fin) r_pdone <= 1'b0;
    end
  end

  // Thing channel: ';' stalls for done_thing before the next entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tst   <= T_IDLE;
      r_rdyl  <= 1'b0;
      r_tout  <= 8'h00;
      r_tnum  <= 4'h0;
      r_tidx  <= '0;
      r_tdone <= 1'b0;
    end else begin
      r_rdyl <= 1'b0;
      if (w_temit) begin
        if (r_tidx < r_tcnt) begin
          r_tout <= w_tent[7:0];
          r_tnum <= w_tent[11:8];
          r_tidx <= r_tidx + 6'd1;
          r_tst  <= (w_tent[7:0] == 8'h3B) ? T_WAITG : T_SEND;
        end else begin
          r_tout <= 8'h24;
          r_tnum <= 4'h0;
          r_tst  <= T_WAIT;
        end
      end else begin
        r_tout <= 8'h00;
        r_tnum <= 4'h0;
        if (r_tst == T_IDLE && w_go) begin
          r_tst  <= T_READY;
          r_rdyl <= 1'b1;
          r_tidx <= '0;
        end
        if (r_tst == T_WAIT && done_fifo2) begin
          r_tdone <= 1'b1;
          r_tst   <= T_IDLE;
        end
      end
      if (w_fin) r_tdone <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cipu_feeder.sv
// Directed vector table plus hand sequences for the CIPU feeder.
module tb_cipu_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_sel;
  logic [7:0] wr_data;
  logic [3:0] wr_num;
  logic       start, done_fifo, done_thing, done_fifo2;
  logic       ready_fifo, ready_lifo;
  logic [7:0] people_thing_in, thing_in;
  logic [3:0] thing_num;
  logic       busy, finish, wr_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cipu_feeder dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_num(wr_num),
    .start(start), .done_fifo(done_fifo),
    .done_thing(done_thing), .done_fifo2(done_fifo2),
    .ready_fifo(ready_fifo), .ready_lifo(ready_lifo),
    .people_thing_in(people_thing_in),
    .thing_in(thing_in), .thing_num(thing_num),
    .busy(busy), .finish(finish), .wr_full(wr_full)
  );

  typedef struct {
    logic       we, sel;
    logic [7:0] d;
    logic [3:0] n;
    logic       st, df, dt, df2;
    logic       rf, rl;
    logic [7:0] pin, tin;
    logic [3:0] tn;
    logic       bz, fin, full;
  } vec_t;

  vec_t tv [21];

  function automatic vec_t mk(
    input logic we, input logic sel,
    input logic [7:0] d, input logic [3:0] n,
    input logic st, input logic df,
    input logic dt, input logic df2,
    input logic rf, input logic rl,
    input logic [7:0] pin, input logic [7:0] tin,
    input logic [3:0] tn, input logic bz,
    input logic fin, input logic full);
    vec_t v;
    v.we = we; v.sel = sel; v.d = d; v.n = n;
    v.st = st; v.df = df; v.dt = dt; v.df2 = df2;
    v.rf = rf; v.rl = rl; v.pin = pin; v.tin = tin;
    v.tn = tn; v.bz = bz; v.fin = fin; v.full = full;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic setin(input logic we, input logic sel,
                       input logic [7:0] d, input logic [3:0] n,
                       input logic st, input logic df,
                       input logic dt, input logic df2);
    wr_en = we; wr_sel = sel; wr_data = d; wr_num = n;
    start = st; done_fifo = df;
    done_thing = dt; done_fifo2 = df2;
  endtask

  task automatic idle();
    setin(0, 0, 8'h00, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, ready_fifo, ready_lifo, people_thing_in,
            thing_in, thing_num, busy, finish, wr_full};
  endfunction

  function automatic logic [31:0] expv(input vec_t v);
    return {7'd0, v.rf, v.rl, v.pin, v.tin, v.tn,
            v.bz, v.fin, v.full};
  endfunction

  initial begin
    tv[0]  = mk(1,0,8'h41,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);
    tv[1]  = mk(1,0,8'h42,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);
    tv[2]  = mk(1,1,8'h58,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);
    tv[3]  = mk(1,1,8'h59,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);
    tv[4]  = mk(1,1,8'h3B,2, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);
    tv[5]  = mk(1,1,8'h5A,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);
    tv[6]  = mk(1,1,8'h3B,1, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);
    tv[7]  = mk(0,0,8'h00,0, 1,0,0,0, 1,1,8'h00,8'h00,0, 1,0,0);
    tv[8]  = mk(0,0,8'h00,0, 0,0,0,0, 0,0,8'h41,8'h58,0, 1,0,0);
    tv[9]  = mk(0,0,8'h00,0, 0,1,1,0, 0,0,8'h42,8'h59,0, 1,0,0);
    tv[10] = mk(0,0,8'h00,0, 0,0,0,0, 0,0,8'h24,8'h3B,2, 1,0,0);
    tv[11] = mk(0,0,8'h00,0, 1,0,0,0, 0,0,8'h00,8'h00,0, 1,0,0);
    tv[12] = mk(0,0,8'h00,0, 0,1,0,0, 0,0,8'h00,8'h00,0, 1,0,0);
    tv[13] = mk(0,0,8'h00,0, 0,0,1,0, 0,0,8'h00,8'h5A,0, 1,0,0);
    tv[14] = mk(0,0,8'h00,0, 0,0,0,0, 0,0,8'h00,8'h3B,1, 1,0,0);
    tv[15] = mk(0,0,8'h00,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 1,0,0);
    tv[16] = mk(0,0,8'h00,0, 0,0,1,0, 0,0,8'h00,8'h24,0, 1,0,0);
    tv[17] = mk(0,0,8'h00,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 1,0,0);
    tv[18] = mk(0,0,8'h00,0, 0,0,0,1, 0,0,8'h00,8'h00,0, 1,0,0);
    tv[19] = mk(0,0,8'h00,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,1,0);
    tv[20] = mk(0,0,8'h00,0, 0,0,0,0, 0,0,8'h00,8'h00,0, 0,0,0);

    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset_outs", outs(), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_outs", outs(), 32'd0);

    for (int i = 0; i < 21; i++) begin
      setin(tv[i].we, tv[i].sel, tv[i].d, tv[i].n,
            tv[i].st, tv[i].df, tv[i].dt, tv[i].df2);
      tick();
      chk($sformatf("vec%0d", i), outs(), expv(tv[i]));
    end
    idle();

    // both buffers empty: only '$' on each channel
    setin(0, 0, 8'h00, 4'h0, 1, 0, 0, 0);
    tick();
    idle();
    chk("empty_ready", {30'd0, ready_fifo, ready_lifo}, 32'd3);
    tick();
    chk("empty_dollar",
        {16'd0, people_thing_in, thing_in}, 32'h2424);
    tick();
    chk("empty_after",
        {16'd0, people_thing_in, thing_in}, 32'h0000);
    setin(0, 0, 8'h00, 4'h0, 0, 0, 0, 1);
    tick();
    idle();
    tick();
    setin(0, 0, 8'h00, 4'h0, 0, 1, 0, 0);
    tick();
    idle();
    chk("empty_nofin_yet", {30'd0, busy, finish}, 32'd2);
    tick();
    chk("empty_finish", {30'd0, busy, finish}, 32'd1);
    tick();
    chk("empty_fin_once", {30'd0, busy, finish}, 32'd0);

    // 33 people writes: last one dropped
    for (int i = 0; i < 33; i++) begin
      logic [7:0] d;
      d = (i == 32) ? 8'h99 : 8'h40 + 8'(i);
      setin(1, 0, d, 4'h0, 0, 0, 0, 0);
      tick();
      if (i == 30) chk("full_at31", {31'd0, wr_full}, 32'd0);
      if (i == 31) chk("full_at32", {31'd0, wr_full}, 32'd1);
    end
    chk("full_after33", {31'd0, wr_full}, 32'd1);
    setin(0, 1, 8'h00, 4'h0, 0, 0, 0, 0);
    #1;
    chk("full_other_sel", {31'd0, wr_full}, 32'd0);
    setin(0, 0, 8'h00, 4'h0, 1, 0, 0, 0);
    tick();
    idle();
    chk("full_ready", {31'd0, ready_fifo}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] d;
      d = 8'h40 + 8'(i);
      tick();
      chk($sformatf("full_ch%0d", i),
          {24'd0, people_thing_in}, {24'd0, d});
      if (i == 0) chk("full_tdollar", {24'd0, thing_in}, 32'h24);
    end
    tick();
    chk("full_pdollar", {24'd0, people_thing_in}, 32'h24);
    setin(0, 0, 8'h00, 4'h0, 0, 1, 0, 1);
    tick();
    idle();
    tick();
    chk("full_finish", {30'd0, busy, finish}, 32'd1);

    // reset in the middle of a thing stream
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      d = 8'h4B + 8'(i);
      setin(1, 1, d, 4'h3, 0, 0, 0, 0);
      tick();
    end
    setin(0, 0, 8'h00, 4'h0, 1, 0, 0, 0);
    tick();
    idle();
    tick();
    chk("rst_pre_tin", {20'd0, thing_num, thing_in}, 32'h34B);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", outs(), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_no_dollar", outs(), 32'd0);
    setin(0, 0, 8'h00, 4'h0, 1, 0, 0, 0);
    tick();
    idle();
    chk("rst_restart_rdy", {30'd0, ready_fifo, ready_lifo}, 32'd3);
    tick();
    chk("rst_restart_dollar",
        {16'd0, people_thing_in, thing_in}, 32'h2424);
    tick();
    chk("rst_restart_end",
        {16'd0, people_thing_in, thing_in}, 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
